// File: rtl/projectile_pool_if.sv
// -----------------------------------------------------------------------------
// projectile_pool_if
// Bundle of control, position and status signals between the game logic
// (master: Player/Aliens side, or a testbench) and projectile_pool (slave).
//   tick, clear, fire_req        : game-step strobe, new-wave restart, fire level
//   player_row/col               : player anchor
//   aliens_row/col               : formation top-left
//   fire_ack, kill_valid/index   : one-cycle event pulses from the pool
//   alive, aliens_defeated       : alien grid state
//   slot_valid/row/col           : flattened live-shot positions
//   busy                         : tick processing in progress
// -----------------------------------------------------------------------------
interface projectile_pool_if #(
   parameter int NUM_SLOTS = 4,
   parameter int GRID_ROWS = 5,
   parameter int GRID_COLS = 10
);
   logic                           tick;
   logic                           clear;
   logic                           fire_req;
   logic                           fire_ack;
   logic [8:0]                     player_row;
   logic [9:0]                     player_col;
   logic [8:0]                     aliens_row;
   logic [9:0]                     aliens_col;
   logic [GRID_ROWS*GRID_COLS-1:0] alive;
   logic [NUM_SLOTS-1:0]           slot_valid;
   logic [9*NUM_SLOTS-1:0]         slot_row;
   logic [10*NUM_SLOTS-1:0]        slot_col;
   logic                           kill_valid;
   logic [5:0]                     kill_index;
   logic                           aliens_defeated;
   logic                           busy;

   modport master (
      output tick, clear, fire_req, player_row, player_col, aliens_row, aliens_col,
      input  fire_ack, alive, slot_valid, slot_row, slot_col, kill_valid,
             kill_index, aliens_defeated, busy
   );

   modport slave (
      input  tick, clear, fire_req, player_row, player_col, aliens_row, aliens_col,
      output fire_ack, alive, slot_valid, slot_row, slot_col, kill_valid,
             kill_index, aliens_defeated, busy
   );
endinterface

// File: rtl/projectile_pool.sv
// -----------------------------------------------------------------------------
// projectile_pool
// Multi-slot player projectile manager. Holds up to NUM_SLOTS shots, accepts
// fire requests subject to a tick-based cooldown, and on every game tick moves
// all shots upward then tests each one (one slot per cycle) against an
// internally owned alien alive-grid.
// Ports:
//   board_clk : system clock
//   reset     : asynchronous active-high reset
//   pool      : projectile_pool_if.slave (inputs tick/clear/fire_req/player/
//               aliens positions; outputs fire_ack, alive, slot_*, kill_*,
//               aliens_defeated, busy)
// -----------------------------------------------------------------------------
module projectile_pool #(
   parameter int NUM_SLOTS    = 4,
   parameter int GRID_ROWS    = 5,
   parameter int GRID_COLS    = 10,
   parameter int PITCH_X_LOG2 = 5,
   parameter int PITCH_Y_LOG2 = 5,
   parameter int ALIEN_W      = 24,
   parameter int ALIEN_H      = 16,
   parameter int STEP         = 4,
   parameter int COOLDOWN     = 3,
   parameter int MUZZLE_OFS   = 8
) (
   input logic              board_clk,
   input logic              reset,
   projectile_pool_if.slave pool
);
   localparam int CELLS = GRID_ROWS * GRID_COLS;
   localparam int IW    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam int CDW   = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
   localparam logic [10:0] X_MASK = 11'((1 << PITCH_X_LOG2) - 1);
   localparam logic [10:0] Y_MASK = 11'((1 << PITCH_Y_LOG2) - 1);

   typedef enum logic [1:0] {IDLE, MOVE, SCAN} state_t;

   state_t               state_q;
   logic [IW-1:0]        idx_q;
   logic [CDW-1:0]       cooldown_q;
   logic                 pending_q;
   logic                 fire_ack_q;
   logic                 defeated_q;
   logic [CELLS-1:0]     alive_q;
   logic [NUM_SLOTS-1:0] slot_valid_q;
   logic [8:0]           slot_row_q [NUM_SLOTS];
   logic [9:0]           slot_col_q [NUM_SLOTS];

   // Lowest-index free slot: descending scan so the smallest index wins.
   logic          free_found_d;
   logic [IW-1:0] free_idx_d;

   always_comb begin
      free_found_d = 1'b0;
      free_idx_d   = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (!slot_valid_q[i]) begin
            free_found_d = 1'b1;
            free_idx_d   = IW'(i);
         end
      end
   end

   // Collision test for the slot currently addressed by idx_q. Differences are
   // 11-bit two's complement; bit 10 set means the shot is left of / above
   // the formation.
   logic [10:0] dx_d, dy_d, cell_x_d, cell_y_d;
   logic        in_grid_d, in_box_d, alive_bit_d, hit_d;
   logic [5:0]  cell_d;

   always_comb begin
      dx_d        = {1'b0, slot_col_q[idx_q]} - {1'b0, pool.aliens_col};
      dy_d        = {2'b0, slot_row_q[idx_q]} - {2'b0, pool.aliens_row};
      cell_x_d    = dx_d >> PITCH_X_LOG2;
      cell_y_d    = dy_d >> PITCH_Y_LOG2;
      in_grid_d   = !dx_d[10] && !dy_d[10] &&
                    (cell_x_d < 11'(GRID_COLS)) && (cell_y_d < 11'(GRID_ROWS));
      in_box_d    = ((dx_d & X_MASK) < 11'(ALIEN_W)) && ((dy_d & Y_MASK) < 11'(ALIEN_H));
      cell_d      = 6'(cell_y_d * 11'(GRID_COLS) + cell_x_d);
      alive_bit_d = in_grid_d ? alive_q[cell_d] : 1'b0;
      hit_d       = (state_q == SCAN) && slot_valid_q[idx_q] && in_grid_d &&
                    in_box_d && alive_bit_d;
   end

   always_ff @(posedge board_clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         cooldown_q   <= '0;
         pending_q    <= 1'b0;
         fire_ack_q   <= 1'b0;
         defeated_q   <= 1'b0;
         alive_q      <= '1;
         slot_valid_q <= '0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_row_q[i] <= '0;
            slot_col_q[i] <= '0;
         end
      end else begin
         fire_ack_q <= 1'b0;
         defeated_q <= (alive_q == '0);
         if (pool.clear) begin
            // New wave: overrides everything, including a scan in flight.
            state_q      <= IDLE;
            idx_q        <= '0;
            cooldown_q   <= '0;
            pending_q    <= 1'b0;
            alive_q      <= '1;
            slot_valid_q <= '0;
         end else begin
            // One tick of slack while busy; a second overlapping tick is lost.
            if ((state_q != IDLE) && pool.tick)
               pending_q <= 1'b1;
            case (state_q)
               IDLE: begin
                  if (pool.tick || pending_q) begin
                     pending_q <= 1'b0;
                     state_q   <= MOVE;
                  end else if (pool.fire_req && (cooldown_q == '0) && free_found_d) begin
                     fire_ack_q <= 1'b1;
                     cooldown_q <= CDW'(COOLDOWN);
                     // A player on row 0 has nowhere to spawn a shot above it.
                     if (pool.player_row != 9'd0) begin
                        slot_valid_q[free_idx_d] <= 1'b1;
                        slot_row_q[free_idx_d]   <= pool.player_row - 9'd1;
                        slot_col_q[free_idx_d]   <= pool.player_col + 10'(MUZZLE_OFS);
                     end
                  end
               end
               MOVE: begin
                  for (int i = 0; i < NUM_SLOTS; i++) begin
                     if (slot_valid_q[i]) begin
                        if (slot_row_q[i] < 9'(STEP))
                           slot_valid_q[i] <= 1'b0;
                        else
                           slot_row_q[i] <= slot_row_q[i] - 9'(STEP);
                     end
                  end
                  if (cooldown_q != '0)
                     cooldown_q <= cooldown_q - CDW'(1);
                  idx_q   <= '0;
                  state_q <= SCAN;
               end
               SCAN: begin
                  // Clearing the bit here makes later slots of this tick miss.
                  if (hit_d) begin
                     alive_q[cell_d]     <= 1'b0;
                     slot_valid_q[idx_q] <= 1'b0;
                  end
                  if (idx_q == IW'(NUM_SLOTS - 1))
                     state_q <= IDLE;
                  else
                     idx_q <= idx_q + IW'(1);
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   // Kill is decoded within the scan cycle so slot i reports at T+2+i.
   assign pool.kill_valid      = hit_d;
   assign pool.kill_index      = hit_d ? cell_d : 6'd0;
   assign pool.fire_ack        = fire_ack_q;
   assign pool.alive           = alive_q;
   assign pool.aliens_defeated = defeated_q;
   assign pool.busy            = (state_q != IDLE);
   assign pool.slot_valid      = slot_valid_q;

   for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot_out
      assign pool.slot_row[9*gi +: 9]   = slot_row_q[gi];
      assign pool.slot_col[10*gi +: 10] = slot_col_q[gi];
   end
endmodule

// File: tb/tb_projectile_pool.sv
module tb_projectile_pool;
   logic board_clk = 1'b0;
   logic reset     = 1'b1;
   int   cyc       = 0;
   int   n_checks  = 0;
   int   n_fail    = 0;
   int   ack_cyc   = -1;

   typedef struct {
      bit is_kill;
      int val;
   } ev_t;
   ev_t exp_q[$];

   logic [3:0]  prev_valid = '0;
   logic [3:0]  mv_valid;
   logic [8:0]  mv_row0;
   logic [49:0] all_ones = '1;

   projectile_pool_if pif ();

   projectile_pool dut (
      .board_clk (board_clk),
      .reset     (reset),
      .pool      (pif.slave)
   );

   always #5 board_clk = ~board_clk;
   always @(posedge board_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end else
         $display("ok   %s: %0d", name, act);
   endtask

   task automatic push_ev(input bit is_kill, input int val);
      ev_t e;
      e.is_kill = is_kill;
      e.val     = val;
      exp_q.push_back(e);
   endtask

   // Scoreboard monitor: every ack/kill the DUT presents is matched against
   // the oldest expected event. For an ack the value is the slot that became
   // valid in that cycle (0 when no slot was allocated).
   task automatic sb_check(input bit is_kill, input int val);
      ev_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL sb_unexpected: got %s val=%0d, required no event", is_kill ? "kill" : "ack", val);
      end else begin
         e = exp_q.pop_front();
         if (e.is_kill != is_kill || e.val != val) begin
            n_fail++;
            $display("FAIL sb_event: got %s val=%0d, required %s val=%0d",
                     is_kill ? "kill" : "ack", val, e.is_kill ? "kill" : "ack", e.val);
         end else
            $display("ok   sb_%s: val=%0d cycle %0d", is_kill ? "kill" : "ack", val, cyc);
      end
   endtask

   always @(negedge board_clk) begin
      if (!reset) begin
         if (pif.fire_ack) begin
            ack_cyc = cyc;
            sb_check(1'b0, int'(pif.slot_valid & ~prev_valid));
         end
         if (pif.kill_valid)
            sb_check(1'b1, int'(pif.kill_index));
         prev_valid = pif.slot_valid;
      end
   end

   task automatic goto(input int n);
      while (cyc < n) begin
         @(posedge board_clk);
         #1;
      end
   endtask

   // Tick then let the full move/scan run; snapshot positions right after MOVE.
   task automatic do_tick();
      @(posedge board_clk); #1 pif.tick = 1'b1;
      @(posedge board_clk); #1 pif.tick = 1'b0;
      @(posedge board_clk); #1;
      mv_valid = pif.slot_valid;
      mv_row0  = pif.slot_row[8:0];
      repeat (6) @(posedge board_clk);
      #1;
   endtask

   task automatic fire_pulse();
      @(posedge board_clk); #1 pif.fire_req = 1'b1;
      @(posedge board_clk); #1 pif.fire_req = 1'b0;
      repeat (2) @(posedge board_clk);
      #1;
   endtask

   task automatic clear_pulse();
      @(posedge board_clk); #1 pif.clear = 1'b1;
      @(posedge board_clk); #1 pif.clear = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, required test end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c0;
      pif.tick = 0; pif.clear = 0; pif.fire_req = 0;
      pif.player_row = 9'd440; pif.player_col = 10'd161;
      pif.aliens_row = 9'd40;  pif.aliens_col = 10'd100;
      repeat (3) @(posedge board_clk);
      #1 reset = 1'b0;
      @(negedge board_clk);
      check("reset_alive", pif.alive, all_ones);
      check("reset_slot_valid", pif.slot_valid, 0);
      check("reset_busy", pif.busy, 0);
      check("reset_defeated", pif.aliens_defeated, 0);
      check("reset_fire_ack", pif.fire_ack, 0);
      check("reset_kill_valid", pif.kill_valid, 0);

      // Fire and hit: shot row 439 col 169, kill of cell 42 on tick 64 (row 183).
      push_ev(1'b0, 1);
      fire_pulse();
      check("spawn_row", pif.slot_row[8:0], 439);
      check("spawn_col", pif.slot_col[9:0], 169);
      for (int k = 1; k <= 64; k++) begin
         if (k == 64) push_ev(1'b1, 42);
         do_tick();
         if (k == 63) check("alive_before_hit", pif.alive, all_ones);
      end
      check("row_at_hit", mv_row0, 183);
      check("hit_slot_freed", pif.slot_valid[0], 0);
      check("hit_alive42", pif.alive[42], 0);
      check("hit_not_defeated", pif.aliens_defeated, 0);
      check("sb_drained_hit", exp_q.size(), 0);

      // Cooldown / pool full: formation off to the right so nothing is hit.
      clear_pulse();
      pif.aliens_col = 10'd700;
      pif.player_row = 9'd59;
      push_ev(1'b0, 1);
      pif.fire_req = 1'b1;
      repeat (3) @(posedge board_clk);
      #1;
      for (int k = 1; k <= 20; k++) begin
         case (k)
            3:  push_ev(1'b0, 2);
            6:  push_ev(1'b0, 4);
            9:  push_ev(1'b0, 8);
            15: push_ev(1'b0, 1);
            18: push_ev(1'b0, 2);
            default: ;
         endcase
         do_tick();
         if (k == 10) check("pool_full", pif.slot_valid, 4'hF);
         if (k == 14) check("row_near_top", mv_row0, 2);
         if (k == 15) begin
            check("top_free_no_wrap", mv_valid[0], 0);
            check("refill_row", pif.slot_row[8:0], 58);
         end
      end
      pif.fire_req = 1'b0;
      check("sb_drained_cooldown", exp_q.size(), 0);

      // Same-tick race: two shots stacked on cell 42.
      clear_pulse();
      pif.player_row = 9'd200;
      push_ev(1'b0, 1);
      fire_pulse();
      repeat (3) do_tick();
      check("race_slot0_row", pif.slot_row[8:0], 187);
      pif.player_row = 9'd188;
      push_ev(1'b0, 2);
      fire_pulse();
      check("race_slot1_row", pif.slot_row[17:9], 187);
      pif.aliens_col = 10'd100;
      push_ev(1'b1, 42);
      do_tick();
      check("race_survivor", pif.slot_valid, 4'b0010);
      check("race_alive42", pif.alive[42], 0);

      // Clear mid-scan.
      @(posedge board_clk); #1;
      c0 = cyc;
      pif.tick = 1'b1;
      goto(c0 + 1); pif.tick = 1'b0;
      goto(c0 + 3); pif.clear = 1'b1;
      @(negedge board_clk);
      check("busy_in_scan", pif.busy, 1);
      goto(c0 + 4); pif.clear = 1'b0;
      @(negedge board_clk);
      check("clear_idle", pif.busy, 0);
      check("clear_alive", pif.alive, all_ones);
      check("clear_slots", pif.slot_valid, 0);
      check("sb_drained_race", exp_q.size(), 0);

      // Fire together with tick: ack only after the scan (cycle c0+7).
      pif.aliens_col = 10'd700;
      pif.player_row = 9'd400;
      repeat (2) @(posedge board_clk);
      #1;
      c0 = cyc;
      push_ev(1'b0, 1);
      pif.tick = 1'b1; pif.fire_req = 1'b1;
      goto(c0 + 1); pif.tick = 1'b0;
      goto(c0 + 8); pif.fire_req = 1'b0;
      check("fire_tick_ack_delay", ack_cyc - c0, 7);

      // Tick during SCAN is held pending and restarts MOVE after one IDLE cycle.
      repeat (2) @(posedge board_clk);
      #1;
      c0 = cyc;
      pif.tick = 1'b1;
      goto(c0 + 1); pif.tick = 1'b0;
      goto(c0 + 3); pif.tick = 1'b1;
      goto(c0 + 4); pif.tick = 1'b0;
      goto(c0 + 6); @(negedge board_clk);
      check("pending_idle_gap", pif.busy, 0);
      goto(c0 + 7); @(negedge board_clk);
      check("pending_move", pif.busy, 1);
      goto(c0 + 12); @(negedge board_clk);
      check("pending_done", pif.busy, 0);

      // Player on row 0: ack without allocation.
      clear_pulse();
      pif.player_row = 9'd0;
      push_ev(1'b0, 0);
      fire_pulse();
      check("row0_no_alloc", pif.slot_valid, 0);

      // Full wipe: move the formation so each fresh shot lands in cell k.
      clear_pulse();
      pif.player_row = 9'd300;
      pif.player_col = 10'd392;
      for (int k = 0; k < 50; k++) begin
         pif.aliens_row = 9'(294 - 32 * (k / 10));
         pif.aliens_col = 10'(399 - 32 * (k % 10));
         if (k == 49) check("not_defeated_49", pif.aliens_defeated, 0);
         push_ev(1'b0, 1);
         push_ev(1'b1, k);
         fire_pulse();
         repeat (3) do_tick();
      end
      repeat (2) @(posedge board_clk);
      #1;
      check("wipe_alive", pif.alive, 0);
      check("wipe_defeated", pif.aliens_defeated, 1);
      check("sb_drained_final", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/projectile_pool.md
# projectile_pool

Multi-slot player-projectile manager for the Space Invaders datapath. It is the parametrised successor to the single-bullet block. It holds up to NUM_SLOTS simultaneous shots and arbitrates fire requests with a cooldown. On every game tick it advances all live shots and resolves shot/alien collisions against an internally owned alive-grid. It sits between the Player/Aliens blocks and Draw_VGA, and runs on board_clk with a single-cycle `tick` strobe derived from the game divider.

## Interface
- NUM_SLOTS, 4: number of concurrent projectiles.
- GRID_ROWS, 5 / GRID_COLS, 10: alien formation size.
- PITCH_X_LOG2, 5 / PITCH_Y_LOG2, 5: alien cell pitch in pixels, as log2 (32 px).
- ALIEN_W, 24 / ALIEN_H, 16: alien hit-box within the cell, anchored at the cell's top-left.
- STEP, 4: pixels moved upward per tick.
- COOLDOWN, 3: ticks between accepted fires.
- MUZZLE_OFS, 8: spawn column offset from player_col.

Ports:
- board_clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- tick  in  1  one-cycle game-step strobe.
- clear  in  1  synchronous new-wave restart.
- fire_req  in  1  level fire request.
- fire_ack  out  1  one-cycle pulse: request accepted.
- player_row  in  9; player_col  in  10: player anchor.
- aliens_row  in  9; aliens_col  in  10: formation top-left.
- alive  out  GRID_ROWS*GRID_COLS  alien alive bits; bit r*GRID_COLS+c.
- slot_valid  out  NUM_SLOTS  live-shot flags.
- slot_row  out  9*NUM_SLOTS; slot_col  out  10*NUM_SLOTS  flattened positions, slot i at [9i+8:9i] / [10i+9:10i].
- kill_valid  out  1  one-cycle pulse per kill.
- kill_index  out  6  index of killed alien.
- aliens_defeated  out  1  high when alive is all zero.
- busy  out  1  tick scan in progress.

## Operation
- Reset values: alive all ones; slot_valid 0; slot_row and slot_col 0; cooldown 0; fire_ack, kill_valid, kill_index, busy all 0; pending 0; FSM in IDLE.
- FSM states are IDLE, MOVE and SCAN.
  - IDLE: if `tick` or `pending` is set, clear pending and go to MOVE. Otherwise evaluate fire.
  - MOVE, one cycle: for every valid slot, if row < STEP, free the slot; otherwise row -= STEP. If cooldown ≠ 0, decrement it. Go to SCAN with idx = 0.
  - SCAN, NUM_SLOTS cycles, one slot per cycle: run the collision test on slot idx. On the last idx, return to IDLE.
- busy = (state ≠ IDLE).
- A `tick` seen outside IDLE sets `pending`. A second tick while pending is already set is dropped.
- Fire acceptance requires all of the following in the same cycle: state IDLE, no tick and no pending, fire_req = 1, cooldown = 0, and at least one free slot.
  - The lowest-index free slot is allocated.
  - It is loaded with row = player_row − 1 and col = player_col + MUZZLE_OFS.
  - cooldown is loaded with COOLDOWN and fire_ack is pulsed.
  - Holding fire_req fires again once cooldown returns to 0.
  - If player_row = 0, the request is acked but no slot is allocated.
- Collision test, all arithmetic 11-bit signed:
  - dx = col − aliens_col, dy = row − aliens_row.
  - The test requires dx ≥ 0 and dy ≥ 0.
  - c = dx >> PITCH_X_LOG2 must be < GRID_COLS; r = dy >> PITCH_Y_LOG2 must be < GRID_ROWS.
  - The in-cell offsets dx mod pitch and dy mod pitch must be < ALIEN_W and < ALIEN_H respectively.
  - alive[r*GRID_COLS+c] must be 1.
  - On a hit: clear that alive bit, free the slot, pulse kill_valid, and drive kill_index = r*GRID_COLS+c.
- Two shots on the same alien in one tick: the lower-index slot kills it. The later slot sees the bit already cleared and continues flying.
- `clear` has top priority. It reloads alive to all ones, frees all slots, zeroes cooldown and pending, and forces IDLE, aborting any scan in progress.

## Timing
- A tick in IDLE at cycle T gives: MOVE at T+1; SCAN at T+2 … T+1+NUM_SLOTS; IDLE at T+2+NUM_SLOTS.
- kill_valid for slot i asserts in cycle T+2+i.
- fire_ack asserts the cycle after the accepting IDLE cycle, and the slot appears valid in that same cycle.
- aliens_defeated is registered and follows the alive update by one cycle.
- Slot position outputs are registered and stable outside MOVE. Draw_VGA samples them asynchronously, so they are tolerated as frame-skewed.
- Ticks must be spaced more than NUM_SLOTS+2 cycles apart for lossless operation. The pending latch covers a single overlap.

## Test plan
- Reset, then check idle outputs: alive = all ones, slot_valid = 0, busy = 0, aliens_defeated = 0.
- Fire and hit: player (440,161), formation (40,100), fire_req for 1 cycle.
  - Expect fire_ack, and slot 0 at row 439, col 169.
  - After 64 ticks the row is 183. Expect a kill with kill_index = 42, alive[42] = 0, and slot 0 freed.
- Cooldown and pool full: fire_req held for 20 ticks with no aliens in the path. Expect acks at ticks 0, 3, 6 and 9. After that there are no further acks until a slot frees at the top; a slot with row < 4 must free with no wrap.
- Same-tick race: two slots stacked on the same alien in the same tick. Expect exactly one kill_valid, for slot 0; slot 1 stays valid.
- Fire/tick collision and pending:
  - fire_req and tick in the same cycle: no ack that cycle; the ack comes after the scan.
  - A tick asserted during SCAN starts MOVE immediately after IDLE is re-entered.
- Clear mid-scan, and full wipe: assert clear during SCAN. Expect IDLE the next cycle, alive = all ones, slot_valid = 0. Separately, killing all 50 aliens drives aliens_defeated to 1.
